// File: rtl/controlador_de_interrupcao.sv
// controlador_de_interrupcao
//   Interrupt controller for the control unit. Gathers the user-mode quantum
//   timer and disk I/O completion, arbitrates them (disk over timer), raises
//   intr only while the processor is in user mode, and holds the accepted
//   cause and disk pid until the kernel clears them.
//
// Ports
//   clk        in   processor clock, rising edge
//   rst        in   asynchronous reset, active low
//   halt       in   processor halted; freezes the quantum counter
//   userMode   in   pulse: enter user mode, restart the quantum
//   kernelMode in   pulse: leave user mode (wins over userMode)
//   inta       in   interrupt acknowledge
//   clearIntr  in   clear the latched cause / pid
//   diskDone   in   pulse: disk I/O complete
//   diskPid    in   [7:0] program id of the finished I/O
//   intr       out  interrupt request (decoded from the state register)
//   intrCode   out  [31:0] latched cause: 0 none, 1 timer, 2 disk
//   intrPid    out  [31:0] latched disk pid, 0 unless the cause is disk

module controlador_de_interrupcao #(
   parameter int unsigned QUANTUM = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic        userMode,
   input  logic        kernelMode,
   input  logic        inta,
   input  logic        clearIntr,
   input  logic        diskDone,
   input  logic [7:0]  diskPid,
   output logic        intr,
   output logic [31:0] intrCode,
   output logic [31:0] intrPid
);

   localparam logic [31:0] QLast = 32'(QUANTUM - 1);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StReq     = 2'd1,
      StService = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        in_user_q, in_user_d;
   logic [31:0] qcount_q, qcount_d;
   logic        timer_pend_q, timer_pend_d;
   logic        disk_pend_q, disk_pend_d;
   logic [7:0]  pid_pend_q, pid_pend_d;
   logic [31:0] code_q, code_d;
   logic [31:0] pid_q, pid_d;

   logic counting;
   logic timer_hit;
   logic accept;
   logic disk_wins;
   logic disk_set;

   assign counting  = in_user_q && !halt;
   assign timer_hit = counting && (qcount_q == QLast);
   assign accept    = (state_q == StReq) && inta;
   assign disk_wins = disk_pend_q;
   // A new completion is taken when nothing is pending, or when the pending
   // one is being consumed in this same cycle.
   assign disk_set  = diskDone && (!disk_pend_q || (accept && disk_wins));

   always_comb begin
      state_d      = state_q;
      in_user_d    = in_user_q;
      qcount_d     = qcount_q;
      timer_pend_d = timer_pend_q;
      disk_pend_d  = disk_pend_q;
      pid_pend_d   = pid_pend_q;
      code_d       = code_q;
      pid_d        = pid_q;

      // Mode tracking: kernelMode and acceptance both beat userMode.
      if (kernelMode || accept) begin
         in_user_d = 1'b0;
      end else if (userMode) begin
         in_user_d = 1'b1;
      end

      // Quantum counter; a userMode pulse restarts the slice.
      if (timer_hit) begin
         qcount_d = '0;
      end else if (counting) begin
         qcount_d = qcount_q + 32'd1;
      end
      if (userMode && !kernelMode) begin
         qcount_d = '0;
      end

      // Pending bits: a fresh event overrides the clear from acceptance.
      if (timer_hit) begin
         timer_pend_d = 1'b1;
      end else if (accept && !disk_wins) begin
         timer_pend_d = 1'b0;
      end

      if (disk_set) begin
         disk_pend_d = 1'b1;
         pid_pend_d  = diskPid;
      end else if (accept && disk_wins) begin
         disk_pend_d = 1'b0;
      end

      // Output registers: acceptance loads, clearIntr zeroes otherwise.
      if (accept) begin
         if (disk_wins) begin
            code_d = 32'd2;
            pid_d  = {24'd0, pid_pend_q};
         end else begin
            code_d = 32'd1;
            pid_d  = '0;
         end
      end else if (clearIntr) begin
         code_d = '0;
         pid_d  = '0;
      end

      unique case (state_q)
         StIdle: begin
            if (in_user_q && (timer_pend_q || disk_pend_q)) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (inta) begin
               state_d = StService;
            end else if (kernelMode) begin
               state_d = StIdle;
            end
         end
         StService: begin
            if (clearIntr) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         in_user_q    <= 1'b0;
         qcount_q     <= '0;
         timer_pend_q <= 1'b0;
         disk_pend_q  <= 1'b0;
         pid_pend_q   <= '0;
         code_q       <= '0;
         pid_q        <= '0;
      end else begin
         state_q      <= state_d;
         in_user_q    <= in_user_d;
         qcount_q     <= qcount_d;
         timer_pend_q <= timer_pend_d;
         disk_pend_q  <= disk_pend_d;
         pid_pend_q   <= pid_pend_d;
         code_q       <= code_d;
         pid_q        <= pid_d;
      end
   end

   assign intr     = (state_q == StReq);
   assign intrCode = code_q;
   assign intrPid  = pid_q;

endmodule

// File: tb/tb_controlador_de_interrupcao.sv
// tb_controlador_de_interrupcao
//   Directed scenarios followed by random traffic, every cycle compared
//   against a behavioural model of the controller.

module tb_controlador_de_interrupcao;

   localparam int unsigned Q = 4;

   logic        clk;
   logic        rst;
   logic        halt;
   logic        userMode;
   logic        kernelMode;
   logic        inta;
   logic        clearIntr;
   logic        diskDone;
   logic [7:0]  diskPid;
   logic        intr;
   logic [31:0] intrCode;
   logic [31:0] intrPid;

   int checks = 0;
   int errors = 0;

   controlador_de_interrupcao #(
      .QUANTUM (Q)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .halt       (halt),
      .userMode   (userMode),
      .kernelMode (kernelMode),
      .inta       (inta),
      .clearIntr  (clearIntr),
      .diskDone   (diskDone),
      .diskPid    (diskPid),
      .intr       (intr),
      .intrCode   (intrCode),
      .intrPid    (intrPid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: phase is "idle", "requesting" or "in service".
   bit          m_user;
   int unsigned m_ticks;
   bit          m_timer;
   bit          m_disk;
   int unsigned m_pidp;
   bit          m_requesting;
   bit          m_servicing;
   int unsigned m_code;
   int unsigned m_pid;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_user = 0; m_ticks = 0; m_timer = 0; m_disk = 0; m_pidp = 0;
      m_requesting = 0; m_servicing = 0; m_code = 0; m_pid = 0;
   endtask

   task automatic model_step(input bit um, input bit km, input bit ht, input bit ia,
                             input bit ci, input bit dd, input int unsigned dp);
      bit taken;
      bit slice_end;
      bit n_req, n_svc;
      taken     = m_requesting && ia;
      slice_end = m_user && !ht && (m_ticks + 1 == Q);

      // next phase, from the current (pre-edge) view
      n_req = m_requesting;
      n_svc = m_servicing;
      if (m_servicing) begin
         if (ci) n_svc = 0;
      end else if (m_requesting) begin
         if (ia) begin n_req = 0; n_svc = 1; end
         else if (km) n_req = 0;
      end else if (m_user && (m_timer || m_disk)) begin
         n_req = 1;
      end

      // latched cause
      if (taken) begin
         m_code = m_disk ? 2 : 1;
         m_pid  = m_disk ? m_pidp : 0;
      end else if (ci) begin
         m_code = 0;
         m_pid  = 0;
      end

      // pending sources: consumption first, then new events
      if (taken) begin
         if (m_disk) m_disk = 0;
         else m_timer = 0;
      end
      if (slice_end) m_timer = 1;
      if (dd && !m_disk) begin
         m_disk = 1;
         m_pidp = dp;
      end

      // slice progress
      if (m_user && !ht) m_ticks = (m_ticks + 1) % Q;
      if (um && !km) m_ticks = 0;

      if (km || taken) m_user = 0;
      else if (um) m_user = 1;

      m_requesting = n_req;
      m_servicing  = n_svc;
   endtask

   task automatic step(input bit um, input bit km, input bit ht, input bit ia,
                       input bit ci, input bit dd, input logic [7:0] dp);
      userMode = um; kernelMode = km; halt = ht; inta = ia;
      clearIntr = ci; diskDone = dd; diskPid = dp;
      model_step(um, km, ht, ia, ci, dd, int'(dp));
      @(posedge clk);
      @(negedge clk);
      check_eq("intr", {31'd0, intr}, {31'd0, m_requesting});
      check_eq("code", intrCode, m_code);
      check_eq("pid", intrPid, m_pid);
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 8'h00);
   endtask

   initial begin
      rst = 1'b0; halt = 0; userMode = 0; kernelMode = 0; inta = 0;
      clearIntr = 0; diskDone = 0; diskPid = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("rst_intr", {31'd0, intr}, 32'd0);
      check_eq("rst_code", intrCode, 32'd0);
      check_eq("rst_pid", intrPid, 32'd0);
      rst = 1'b1;

      // Timer: userMode at edge 0, intr high after edge 5.
      step(1, 0, 0, 0, 0, 0, 8'h00);
      idle_steps(4);
      check_eq("tmr_early", {31'd0, intr}, 32'd0);
      idle_steps(1);
      check_eq("tmr_intr", {31'd0, intr}, 32'd1);
      step(0, 0, 0, 1, 0, 0, 8'h00);
      check_eq("tmr_code", intrCode, 32'd1);
      check_eq("tmr_ack_intr", {31'd0, intr}, 32'd0);
      step(0, 0, 0, 0, 1, 0, 8'h00);
      check_eq("tmr_clr", intrCode, 32'd0);

      // Disk: request two cycles after diskDone, pid 0x2A reported.
      step(1, 0, 0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 0, 1, 8'h2A);
      check_eq("dsk_early", {31'd0, intr}, 32'd0);
      idle_steps(1);
      check_eq("dsk_intr", {31'd0, intr}, 32'd1);
      step(0, 0, 0, 1, 0, 1, 8'h11);
      check_eq("dsk_code", intrCode, 32'd2);
      check_eq("dsk_pid", intrPid, 32'h2A);
      step(0, 0, 0, 0, 1, 0, 8'h00);
      check_eq("dsk_clr", intrPid, 32'd0);

      // Kernel-mode completion waits for the next userMode.
      step(0, 1, 0, 0, 0, 0, 8'h00);
      step(0, 0, 0, 0, 0, 1, 8'h33);
      idle_steps(3);
      check_eq("krn_quiet", {31'd0, intr}, 32'd0);
      step(1, 0, 0, 0, 0, 0, 8'h00);
      idle_steps(1);
      check_eq("krn_intr", {31'd0, intr}, 32'd1);
      step(0, 0, 0, 1, 0, 0, 8'h00);
      check_eq("krn_code", intrCode, 32'd2);

      // Reset while in service clears outputs asynchronously.
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_eq("ar_intr", {31'd0, intr}, 32'd0);
      check_eq("ar_code", intrCode, 32'd0);
      check_eq("ar_pid", intrPid, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      idle_steps(2);
      step(1, 0, 0, 0, 0, 0, 8'h00);
      idle_steps(1);
      check_eq("ar_idle", {31'd0, intr}, 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 6) == 0), ($urandom_range(0, 7) == 0),
              8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/controlador_de_interrupcao.md
# controlador_de_interrupcao

Interrupt controller feeding the control unit's `intr` input and the `gic`/`gip` read path. Collects two interrupt sources: the user-mode time-slice quantum timer and disk I/O completion. Arbitrates them and raises `intr` only while the processor runs in user mode. Holds the winning interrupt code and disk program id until the kernel clears them with `clearIntr`.

## Interface

Parameters:
- `QUANTUM`, default 1000: user-mode cycles per time slice; legal range 2 to 2^32-1.

Ports:
- `clk` in 1: processor clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `halt` in 1: processor halted; freezes the quantum counter.
- `userMode` in 1: one-cycle pulse from the control unit (`exec`/`exec_again`); enters user mode.
- `kernelMode` in 1: one-cycle pulse from the control unit (`syscall`); leaves user mode.
- `inta` in 1: interrupt acknowledge from the control unit.
- `clearIntr` in 1: clear request from the control unit (`cic`).
- `diskDone` in 1: one-cycle pulse from the disk controller on I/O completion.
- `diskPid` in 8: program id of the finished I/O; valid with `diskDone`.
- `intr` out 1: interrupt request to the control unit.
- `intrCode` out 32: latched cause, zero-extended; 0 = none, 1 = timer, 2 = disk.
- `intrPid` out 32: latched disk program id, zero-extended; 0 unless the cause is disk.

## Operation

Internal registers:
- `inUser` flag.
- 32-bit `qcount`.
- Pending bits `timerPend` and `diskPend`, plus an 8-bit `pidPend`.
- State: IDLE / REQ / SERVICE.
- Code and pid output registers.

Reset value of all of the above is 0. IDLE is the reset state.

Mode tracking:
- `userMode` sets `inUser` and loads `qcount` = 0.
- `kernelMode` clears `inUser`.
- Acceptance of an interrupt (REQ→SERVICE) also clears `inUser`.
- If `userMode` and `kernelMode` are both high in the same cycle, `kernelMode` wins.

Quantum timer:
- Counts while `inUser` && !`halt`.
- When `qcount` == QUANTUM-1: set `timerPend` and wrap `qcount` to 0.
- Frozen (value held) when not in user mode or when halted.
- If `timerPend` is already set, the wrap still occurs and no second request is queued.

Disk pending:
- `diskDone` sets `diskPend` and loads `pidPend` = `diskPid`.
- A `diskDone` while `diskPend` is already set is dropped; the first pid is kept.

State machine:
- IDLE → REQ when `inUser` && (`timerPend` || `diskPend`).
- REQ: `intr` = 1. Stays in REQ until `inta`.
- REQ + `inta` → SERVICE. Priority is disk over timer:
  - Disk wins: `intrCode` = 2, `intrPid` = `pidPend`, clear `diskPend`.
  - Otherwise: `intrCode` = 1, `intrPid` = 0, clear `timerPend`.
  - The losing pending bit stays set.
- REQ with `kernelMode` (and no `inta`) → IDLE. `intr` drops and pending bits are kept.
- SERVICE: `intr` = 0. Stays until `clearIntr`, then → IDLE and zeroes `intrCode` and `intrPid`.
- `clearIntr` in IDLE or REQ zeroes the output registers only; it does not change state.
- `inta` in IDLE or SERVICE has no effect; this covers `pre_io` acknowledges.

Simultaneous events:
- A source event in the same cycle that clears its own pending bit on acceptance leaves the bit set; the new event wins.
- A still-pending source re-requests only after SERVICE → IDLE and a later `userMode`.

## Timing

- All outputs are registered or decoded from the state register only; no combinational path from any input to `intr`.
- Latency, with an event at edge N and `inUser` = 1:
  - Pending bit set at N+1.
  - REQ entered and `intr` high at N+2.
- `inta` sampled at edge M in REQ: `intr` low after M, and `intrCode`/`intrPid` valid after M.
- `clearIntr` sampled at edge K in SERVICE: outputs are 0 after K.
- Timer: starting from a `userMode` pulse at edge 0, `timerPend` sets at edge QUANTUM. Every halted cycle adds one cycle of delay.
- Reset mid-operation clears everything asynchronously. Any in-flight request is lost.

## Test plan

- QUANTUM=4, `userMode` pulse at edge 0, no halt → `intr` high after edge 5; `inta` → `intrCode`=1, `intrPid`=0, `intr`=0.
- `diskDone` with `diskPid`=0x2A while in user mode → `intr` 2 cycles later; `inta` → `intrCode`=2, `intrPid`=0x2A; `clearIntr` → both 0, state IDLE.
- Timer and disk both pending → first acceptance gives code 2; after `clearIntr` and a new `userMode`, `intr` reasserts and acceptance gives code 1.
- `diskDone` in kernel mode (after `kernelMode`) → `intr` stays 0; a later `userMode` → `intr` after 1 cycle with code 2.
- `halt` held for 3 cycles during the quantum with QUANTUM=4 → `timerPend` is delayed by exactly 3 cycles; a second `diskDone` (pid 0x11) while `diskPend` is set → the pid 0x2A from the first event is reported.
- `rst` asserted low while in SERVICE with code 2 → `intr`, `intrCode`, `intrPid` are 0 immediately; the controller is in IDLE after release.
